// File: rtl/draw_rect_ctl_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank strobes and 12-bit RGB.
// The in/out modports are the stage-facing views; master/slave are equivalent aliases.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in     (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out    (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_rect_ctl.sv
// Pong paddle controller: latches/clamps both paddle Y values once per frame and overlays them.
// Optional macro DRAW_RECT_P2_COLOR_EN draws the player-2 paddle in green instead of RECT_COLOR.
module draw_rect_ctl #(
    parameter int unsigned x_fix_position_player_1 = 32,
    parameter int unsigned x_fix_position_player_2 = 972,
    parameter int unsigned width                   = 20,
    parameter int unsigned height                  = 100,
    parameter logic [11:0] RECT_COLOR              = 12'hF_F_F
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic [11:0] mouse_ypos,
    input  logic        screen_idle,
    input  logic        screen_single,
    input  logic [9:0]  input_pos,
    output logic [9:0]  output_pos,
    vga_if.in           draw_bg_if,
    vga_if.out          draw_rect_if
);

    localparam int unsigned V_ACTIVE = 768;

    localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - height);
    localparam logic [11:0] HEIGHT12 = 12'(height);
    localparam logic [11:0] X1_LO    = 12'(x_fix_position_player_1);
    localparam logic [11:0] X1_HI    = 12'(x_fix_position_player_1 + width);
    localparam logic [11:0] X2_LO    = 12'(x_fix_position_player_2);
    localparam logic [11:0] X2_HI    = 12'(x_fix_position_player_2 + width);
    localparam bit          HAS_WIDTH = (width != 0);

`ifdef DRAW_RECT_P2_COLOR_EN
    localparam logic [11:0] P2_COLOR = 12'h0_F_0;
`else
    localparam logic [11:0] P2_COLOR = RECT_COLOR;
`endif

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_DUAL   = 2'd2;

    logic [9:0]  p1_y;
    logic [9:0]  p2_y;

    logic        frame_start_c;
    logic [9:0]  p1_clamp_c;
    logic [9:0]  p2_clamp_c;
    logic [11:0] hc_c;
    logic [11:0] vc_c;
    logic [11:0] p1_top_c;
    logic [11:0] p1_bot_c;
    logic [11:0] p2_top_c;
    logic [11:0] p2_bot_c;
    logic        in_p1_c;
    logic        in_p2_c;
    logic [1:0]  mode_c;
    logic [11:0] rgb_nxt_c;

    // Frame-start detect and clamping of the incoming paddle positions.
    always_comb begin
        frame_start_c = (draw_bg_if.vcount == 11'd0) && (draw_bg_if.hcount == 11'd0);
        p1_clamp_c    = (mouse_ypos >= Y_MAX) ? Y_MAX[9:0] : mouse_ypos[9:0];
        p2_clamp_c    = ({2'b00, input_pos} >= Y_MAX) ? Y_MAX[9:0] : input_pos;
    end

    // Hit tests against the frame-stable paddle positions, all in 12-bit unsigned.
    always_comb begin
        hc_c     = {1'b0, draw_bg_if.hcount};
        vc_c     = {1'b0, draw_bg_if.vcount};
        p1_top_c = {2'b00, p1_y};
        p1_bot_c = p1_top_c + HEIGHT12;
        p2_top_c = {2'b00, p2_y};
        p2_bot_c = p2_top_c + HEIGHT12;
        in_p1_c  = HAS_WIDTH && (hc_c >= X1_LO) && (hc_c < X1_HI)
                             && (vc_c >= p1_top_c) && (vc_c < p1_bot_c);
        in_p2_c  = HAS_WIDTH && (hc_c >= X2_LO) && (hc_c < X2_HI)
                             && (vc_c >= p2_top_c) && (vc_c < p2_bot_c);
    end

    // Mode decode (idle beats single) and pixel selection; blanking always passes rgb through.
    always_comb begin
        mode_c    = MODE_DUAL;
        rgb_nxt_c = draw_bg_if.rgb;
        if (screen_idle) begin
            mode_c = MODE_IDLE;
        end else if (screen_single) begin
            mode_c = MODE_SINGLE;
        end
        if (!draw_bg_if.hblnk && !draw_bg_if.vblnk) begin
            case (mode_c)
                MODE_SINGLE: begin
                    if (in_p1_c) rgb_nxt_c = RECT_COLOR;
                end
                MODE_DUAL: begin
                    if (in_p1_c)      rgb_nxt_c = RECT_COLOR;
                    else if (in_p2_c) rgb_nxt_c = P2_COLOR;
                end
                default: rgb_nxt_c = draw_bg_if.rgb;
            endcase
        end
    end

    // Per-frame position latch and the single-cycle output pipeline stage.
    always_ff @(posedge clk65MHz or negedge rst) begin
        if (!rst) begin
            p1_y                <= 10'd0;
            p2_y                <= 10'd0;
            output_pos          <= 10'd0;
            draw_rect_if.vcount <= 11'd0;
            draw_rect_if.vsync  <= 1'b0;
            draw_rect_if.vblnk  <= 1'b0;
            draw_rect_if.hcount <= 11'd0;
            draw_rect_if.hsync  <= 1'b0;
            draw_rect_if.hblnk  <= 1'b0;
            draw_rect_if.rgb    <= 12'd0;
        end else begin
            if (frame_start_c) begin
                p1_y <= p1_clamp_c;
                p2_y <= p2_clamp_c;
            end
            output_pos          <= p1_y;
            draw_rect_if.vcount <= draw_bg_if.vcount;
            draw_rect_if.vsync  <= draw_bg_if.vsync;
            draw_rect_if.vblnk  <= draw_bg_if.vblnk;
            draw_rect_if.hcount <= draw_bg_if.hcount;
            draw_rect_if.hsync  <= draw_bg_if.hsync;
            draw_rect_if.hblnk  <= draw_bg_if.hblnk;
            draw_rect_if.rgb    <= rgb_nxt_c;
        end
    end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl: drives individual pixels of the stream and checks the 1-clk output.
module tb_draw_rect_ctl;

    localparam logic [11:0] RECT_C = 12'hFFF;
`ifdef DRAW_RECT_P2_COLOR_EN
    localparam logic [11:0] P2_C = 12'h0F0;
`else
    localparam logic [11:0] P2_C = 12'hFFF;
`endif

    logic        clk;
    logic        rst;
    logic [11:0] mouse_ypos;
    logic        screen_idle;
    logic        screen_single;
    logic [9:0]  input_pos;
    logic [9:0]  output_pos;

    int n_checks;
    int n_fail;

    vga_if bg ();
    vga_if rect ();

    draw_rect_ctl dut (
        .clk65MHz      (clk),
        .rst           (rst),
        .mouse_ypos    (mouse_ypos),
        .screen_idle   (screen_idle),
        .screen_single (screen_single),
        .input_pos     (input_pos),
        .output_pos    (output_pos),
        .draw_bg_if    (bg),
        .draw_rect_if  (rect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one pixel, then sample 1 ns after the edge that registers it.
    task automatic px(input logic [10:0] h, input logic [10:0] v,
                      input logic hb, input logic vb, input logic [11:0] c);
        bg.hcount = h;
        bg.vcount = v;
        bg.hsync  = h[0];
        bg.vsync  = v[0];
        bg.hblnk  = hb;
        bg.vblnk  = vb;
        bg.rgb    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (rect.rgb !== 12'd0 || rect.hcount !== 11'd0 || rect.vcount !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_rgb_cnt: rgb=%h h=%0d v=%0d expected 0/0/0", rect.rgb, rect.hcount, rect.vcount);
        end
        n_checks++;
        if ({rect.hsync, rect.vsync, rect.hblnk, rect.vblnk} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 0000", {rect.hsync, rect.vsync, rect.hblnk, rect.vblnk});
        end
        n_checks++;
        if (output_pos !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_output_pos: got %0d expected 0", output_pos);
        end
        rst = 1'b1;
    endtask

    task automatic test_idle;
        screen_idle = 1'b1; screen_single = 1'b0; mouse_ypos = 12'd100; input_pos = 10'd0;
        px(11'd0, 11'd0, 1'b0, 1'b0, 12'h111);
        n_checks++;
        if (rect.rgb !== 12'h111) begin
            n_fail++;
            $display("FAIL idle_latch_pixel: rgb=%h expected 111", rect.rgb);
        end
        n_checks++;
        if (output_pos !== 10'd0) begin
            n_fail++;
            $display("FAIL idle_pos_before: got %0d expected 0", output_pos);
        end
        px(11'd1, 11'd0, 1'b0, 1'b0, 12'h112);
        n_checks++;
        if (output_pos !== 10'd100) begin
            n_fail++;
            $display("FAIL idle_pos_after: got %0d expected 100", output_pos);
        end
        // Sweep across the player-1 paddle span; idle must never paint.
        for (int i = 0; i < 30; i++) begin
            px(11'(25 + i), 11'd150, 1'b0, 1'b0, 12'(i * 3 + 7));
            n_checks++;
            if (rect.rgb !== 12'(i * 3 + 7) || rect.hcount !== 11'(25 + i) || rect.vcount !== 11'd150
                || rect.hsync !== rect.hcount[0]) begin
                n_fail++;
                $display("FAIL idle_pass_%0d: rgb=%h h=%0d v=%0d expected %h/%0d/150",
                         i, rect.rgb, rect.hcount, rect.vcount, 12'(i * 3 + 7), 25 + i);
            end
        end
    endtask

    task automatic test_single;
        screen_idle = 1'b0; screen_single = 1'b1; mouse_ypos = 12'd200;
        px(11'd0, 11'd0, 1'b0, 1'b0, 12'h200);
        px(11'd1, 11'd0, 1'b0, 1'b0, 12'h201);
        n_checks++;
        if (output_pos !== 10'd200) begin
            n_fail++;
            $display("FAIL single_pos: got %0d expected 200", output_pos);
        end
        px(11'd37, 11'd250, 1'b0, 1'b0, 12'h222);
        n_checks++;
        if (rect.rgb !== RECT_C) begin
            n_fail++;
            $display("FAIL single_p1: rgb=%h expected %h", rect.rgb, RECT_C);
        end
        px(11'd977, 11'd250, 1'b0, 1'b0, 12'h333);
        n_checks++;
        if (rect.rgb !== 12'h333) begin
            n_fail++;
            $display("FAIL single_no_p2: rgb=%h expected 333", rect.rgb);
        end
        // Top-of-screen paddle and its exact edges.
        mouse_ypos = 12'd0;
        px(11'd0, 11'd0, 1'b0, 1'b0, 12'h400);
        px(11'd32, 11'd0, 1'b0, 1'b0, 12'h444);
        n_checks++;
        if (rect.rgb !== RECT_C) begin
            n_fail++;
            $display("FAIL top_row_left: rgb=%h expected %h", rect.rgb, RECT_C);
        end
        px(11'd51, 11'd99, 1'b0, 1'b0, 12'h445);
        n_checks++;
        if (rect.rgb !== RECT_C) begin
            n_fail++;
            $display("FAIL top_bottom_right: rgb=%h expected %h", rect.rgb, RECT_C);
        end
        px(11'd32, 11'd100, 1'b0, 1'b0, 12'h446);
        n_checks++;
        if (rect.rgb !== 12'h446) begin
            n_fail++;
            $display("FAIL top_below: rgb=%h expected 446", rect.rgb);
        end
        px(11'd31, 11'd0, 1'b0, 1'b0, 12'h447);
        n_checks++;
        if (rect.rgb !== 12'h447) begin
            n_fail++;
            $display("FAIL top_left_of: rgb=%h expected 447", rect.rgb);
        end
        px(11'd52, 11'd0, 1'b0, 1'b0, 12'h448);
        n_checks++;
        if (rect.rgb !== 12'h448) begin
            n_fail++;
            $display("FAIL top_right_of: rgb=%h expected 448", rect.rgb);
        end
    endtask

    task automatic test_clamp;
        screen_idle = 1'b0; screen_single = 1'b1; mouse_ypos = 12'd700;
        px(11'd0, 11'd0, 1'b0, 1'b0, 12'h500);
        px(11'd1, 11'd0, 1'b0, 1'b0, 12'h501);
        n_checks++;
        if (output_pos !== 10'd668) begin
            n_fail++;
            $display("FAIL clamp_700: got %0d expected 668", output_pos);
        end
        mouse_ypos = 12'd300;
        px(11'd37, 11'd10, 1'b0, 1'b0, 12'h502);
        n_checks++;
        if (rect.rgb !== 12'h502 || output_pos !== 10'd668) begin
            n_fail++;
            $display("FAIL clamp_hold: rgb=%h pos=%0d expected 502/668", rect.rgb, output_pos);
        end
        px(11'd37, 11'd767, 1'b0, 1'b0, 12'h503);
        n_checks++;
        if (rect.rgb !== RECT_C) begin
            n_fail++;
            $display("FAIL clamp_last_line: rgb=%h expected %h", rect.rgb, RECT_C);
        end
        px(11'd37, 11'd667, 1'b0, 1'b0, 12'h504);
        n_checks++;
        if (rect.rgb !== 12'h504) begin
            n_fail++;
            $display("FAIL clamp_above: rgb=%h expected 504", rect.rgb);
        end
        px(11'd37, 11'd768, 1'b0, 1'b1, 12'h505);
        n_checks++;
        if (rect.rgb !== 12'h505) begin
            n_fail++;
            $display("FAIL clamp_vblnk: rgb=%h expected 505", rect.rgb);
        end
        px(11'd0, 11'd0, 1'b0, 1'b0, 12'h506);
        n_checks++;
        if (output_pos !== 10'd668) begin
            n_fail++;
            $display("FAIL clamp_latch_cycle: got %0d expected 668", output_pos);
        end
        px(11'd1, 11'd0, 1'b0, 1'b0, 12'h507);
        n_checks++;
        if (output_pos !== 10'd300) begin
            n_fail++;
            $display("FAIL clamp_new_frame: got %0d expected 300", output_pos);
        end
        mouse_ypos = 12'hFFF;
        px(11'd0, 11'd0, 1'b0, 1'b0, 12'h508);
        px(11'd1, 11'd0, 1'b0, 1'b0, 12'h509);
        n_checks++;
        if (output_pos !== 10'd668) begin
            n_fail++;
            $display("FAIL clamp_max: got %0d expected 668", output_pos);
        end
    endtask

    task automatic test_dual;
        screen_idle = 1'b0; screen_single = 1'b0; mouse_ypos = 12'd100; input_pos = 10'd400;
        px(11'd0, 11'd0, 1'b0, 1'b0, 12'h600);
        px(11'd972, 11'd400, 1'b0, 1'b0, 12'h601);
        n_checks++;
        if (rect.rgb !== P2_C) begin
            n_fail++;
            $display("FAIL dual_p2_topleft: rgb=%h expected %h", rect.rgb, P2_C);
        end
        px(11'd991, 11'd499, 1'b0, 1'b0, 12'h602);
        n_checks++;
        if (rect.rgb !== P2_C) begin
            n_fail++;
            $display("FAIL dual_p2_botright: rgb=%h expected %h", rect.rgb, P2_C);
        end
        px(11'd972, 11'd500, 1'b0, 1'b0, 12'h603);
        n_checks++;
        if (rect.rgb !== 12'h603) begin
            n_fail++;
            $display("FAIL dual_p2_below: rgb=%h expected 603", rect.rgb);
        end
        px(11'd992, 11'd450, 1'b0, 1'b0, 12'h604);
        n_checks++;
        if (rect.rgb !== 12'h604) begin
            n_fail++;
            $display("FAIL dual_p2_right: rgb=%h expected 604", rect.rgb);
        end
        px(11'd32, 11'd100, 1'b0, 1'b0, 12'h605);
        n_checks++;
        if (rect.rgb !== RECT_C) begin
            n_fail++;
            $display("FAIL dual_p1: rgb=%h expected %h", rect.rgb, RECT_C);
        end
        input_pos = 10'd1000;
        px(11'd0, 11'd0, 1'b0, 1'b0, 12'h606);
        px(11'd980, 11'd767, 1'b0, 1'b0, 12'h607);
        n_checks++;
        if (rect.rgb !== P2_C) begin
            n_fail++;
            $display("FAIL dual_p2_clamp_in: rgb=%h expected %h", rect.rgb, P2_C);
        end
        px(11'd980, 11'd667, 1'b0, 1'b0, 12'h608);
        n_checks++;
        if (rect.rgb !== 12'h608) begin
            n_fail++;
            $display("FAIL dual_p2_clamp_out: rgb=%h expected 608", rect.rgb);
        end
    endtask

    task automatic test_priority;
        screen_idle = 1'b1; screen_single = 1'b1;
        px(11'd40, 11'd150, 1'b0, 1'b0, 12'h701);
        n_checks++;
        if (rect.rgb !== 12'h701) begin
            n_fail++;
            $display("FAIL prio_idle_wins: rgb=%h expected 701", rect.rgb);
        end
        screen_idle = 1'b0;
        px(11'd41, 11'd150, 1'b0, 1'b0, 12'h702);
        n_checks++;
        if (rect.rgb !== RECT_C) begin
            n_fail++;
            $display("FAIL prio_mode_switch: rgb=%h expected %h", rect.rgb, RECT_C);
        end
        screen_single = 1'b0;
        px(11'd42, 11'd150, 1'b1, 1'b0, 12'h703);
        n_checks++;
        if (rect.rgb !== 12'h703 || rect.hblnk !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_hblnk: rgb=%h hblnk=%b expected 703/1", rect.rgb, rect.hblnk);
        end
        px(11'd42, 11'd150, 1'b0, 1'b1, 12'h704);
        n_checks++;
        if (rect.rgb !== 12'h704 || rect.vblnk !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_vblnk: rgb=%h vblnk=%b expected 704/1", rect.rgb, rect.vblnk);
        end
    endtask

    task automatic test_reset_mid;
        screen_idle = 1'b0; screen_single = 1'b1;
        px(11'd200, 11'd61, 1'b0, 1'b0, 12'h777);
        n_checks++;
        if (rect.rgb !== 12'h777 || output_pos !== 10'd100) begin
            n_fail++;
            $display("FAIL rmid_before: rgb=%h pos=%0d expected 777/100", rect.rgb, output_pos);
        end
        rst = 1'b0;
        px(11'd201, 11'd61, 1'b0, 1'b0, 12'h778);
        n_checks++;
        if (rect.rgb !== 12'd0 || rect.hcount !== 11'd0 || rect.vcount !== 11'd0
            || rect.vsync !== 1'b0 || output_pos !== 10'd0) begin
            n_fail++;
            $display("FAIL rmid_in_reset: rgb=%h h=%0d v=%0d pos=%0d expected all 0",
                     rect.rgb, rect.hcount, rect.vcount, output_pos);
        end
        rst = 1'b1;
        // Positions were cleared, so player 1 now sits on row 0.
        px(11'd37, 11'd50, 1'b0, 1'b0, 12'h779);
        n_checks++;
        if (rect.rgb !== RECT_C || rect.hcount !== 11'd37 || rect.vcount !== 11'd50) begin
            n_fail++;
            $display("FAIL rmid_resume_p1: rgb=%h h=%0d v=%0d expected %h/37/50",
                     rect.rgb, rect.hcount, rect.vcount, RECT_C);
        end
        screen_single = 1'b0;
        px(11'd977, 11'd50, 1'b0, 1'b0, 12'h77A);
        n_checks++;
        if (rect.rgb !== P2_C) begin
            n_fail++;
            $display("FAIL rmid_resume_p2: rgb=%h expected %h", rect.rgb, P2_C);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        mouse_ypos    = 12'd0;
        screen_idle   = 1'b0;
        screen_single = 1'b0;
        input_pos     = 10'd0;
        bg.hcount     = 11'd5;
        bg.vcount     = 11'd5;
        bg.hsync      = 1'b1;
        bg.vsync      = 1'b1;
        bg.hblnk      = 1'b1;
        bg.vblnk      = 1'b1;
        bg.rgb        = 12'hABC;

        test_reset();
        test_idle();
        test_single();
        test_clamp();
        test_dual();
        test_priority();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
